// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave that turns each accepted transfer into one req/ack access on
// a simple register bus. Size, alignment and privilege are checked when the
// address phase is accepted; the register bus can stall the AHB side for as
// long as it needs.

package ahb_pkg;
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef logic [2:0] hburst_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef logic [2:0] hsize_t;
   typedef logic [3:0] hprot_t;

   // NONSEQ and SEQ carry data; IDLE and BUSY do not
   function automatic logic ahb_xfer(htrans_e t);
      return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
   endfunction
endpackage

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer in flight, zero-wait OKAY
// WAIT  | reg_req high, AHB stalled until reg_ack
// RESP  | register access done, OKAY, hrdata valid
// ERR1  | first ERROR cycle, hreadyout low
// ERR2  | second ERROR cycle, hreadyout high
module ahb_reg_bridge
   import ahb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter bit REQ_PRIV = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hsel,
   input  logic [AW-1:0]     haddr,
   input  htrans_e           htrans,
   input  logic              hwrite,
   input  hsize_t            hsize,
   input  hburst_t           hburst,
   input  hprot_t            hprot,
   input  logic [DW-1:0]     hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output hresp_e            hresp,
   output logic [DW-1:0]     hrdata,
   output logic              reg_req,
   output logic              reg_we,
   output logic [AW-1:0]     reg_addr,
   output logic [DW-1:0]     reg_wdata,
   output logic [DW/8-1:0]   reg_wstrb,
   input  logic              reg_ack,
   input  logic              reg_err,
   input  logic [DW-1:0]     reg_rdata
);

   localparam int STRB_W = DW / 8;
   localparam int LB     = $clog2(STRB_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_ERR1,
      ST_ERR2
   } state_e;

   state_e            state;
   state_e            state_nxt;
   logic              in_ready;
   logic              accept;
   logic              size_err;
   logic              align_err;
   logic              priv_err;
   logic              xfer_err;
   logic [STRB_W-1:0] strb_calc;
   logic              unused_inputs;

   // Burst type is irrelevant: every beat stands alone. Only hprot[1] matters.
   assign unused_inputs = ^{hburst, hprot[3:2], hprot[0]};

   assign in_ready  = (state == ST_IDLE) || (state == ST_RESP) || (state == ST_ERR2);
   assign accept    = hsel & hready & ahb_xfer(htrans);
   assign size_err  = (hsize > hsize_t'(LB));
   // When hsize == LB the shifted one wraps to zero and the mask becomes all ones,
   // which is the right answer; larger sizes are already flagged by size_err.
   assign align_err = |(haddr[LB-1:0] & ((LB'(1) << hsize) - LB'(1)));
   assign priv_err  = REQ_PRIV && !hprot[1];
   assign xfer_err  = size_err | align_err | priv_err;

   // write data is passed straight through; the master holds it during WAIT
   assign reg_wdata = hwdata;

   // byte lane i is enabled when it falls in the same size-aligned block as haddr
   always_comb begin
      strb_calc = '0;
      for (int i = 0; i < STRB_W; i++) begin
         if ((LB'(i) >> hsize) == (haddr[LB-1:0] >> hsize)) begin
            strb_calc[i] = 1'b1;
         end
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_RESP, ST_ERR2: begin
            if (accept) begin
               state_nxt = xfer_err ? ST_ERR1 : ST_WAIT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (reg_ack) begin
               state_nxt = reg_err ? ST_ERR1 : ST_RESP;
            end
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // outputs are registered from the next state so nothing is decoded after the flops
   always_ff @(posedge clk) begin
      if (reset) begin
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
         hrdata    <= '0;
         reg_req   <= 1'b0;
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_wstrb <= '0;
      end else begin
         hreadyout <= !((state_nxt == ST_WAIT) || (state_nxt == ST_ERR1));
         hresp     <= ((state_nxt == ST_ERR1) || (state_nxt == ST_ERR2)) ? HRESP_ERROR
                                                                         : HRESP_OKAY;
         reg_req   <= (state_nxt == ST_WAIT);
         if (in_ready && (state_nxt == ST_WAIT)) begin
            reg_we    <= hwrite;
            reg_addr  <= haddr;
            reg_wstrb <= strb_calc;
         end
         if ((state == ST_WAIT) && reg_ack && !reg_err) begin
            hrdata <= reg_rdata;
         end
      end
   end

endmodule

// File: doc/ahb_reg_bridge.md
# ahb_reg_bridge

AHB-Lite slave that terminates AHB transfers and converts each one into a single request/acknowledge access on a simple register bus. It sits directly downstream of the AHB interconnect and uses the `ahb_pkg` types (`htrans_e`, `hburst_t`, `hresp_e`, `hsize_t`, `hprot_t`, `ahb_xfer`). It checks size, alignment and privilege, stalls the bus with wait states until the register bus acknowledges, and generates the standard two-cycle ERROR response.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width; must be 32 or 64.
- `REQ_PRIV`, 0: when 1, user-mode accesses (`hprot[1]==0`) get an ERROR response.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `hsel` in 1: slave select.
- `haddr` in AW: byte address.
- `htrans` in 2 (`htrans_e`): transfer type.
- `hwrite` in 1: 1 = write.
- `hsize` in 3 (`hsize_t`): transfer size.
- `hburst` in 3 (`hburst_t`): ignored; each beat is handled independently.
- `hprot` in 4 (`hprot_t`): protection attributes.
- `hwdata` in DW: write data, valid in the data phase.
- `hready` in 1: bus-wide ready.
- `hreadyout` out 1: slave ready.
- `hresp` out 2 (`hresp_e`): OKAY or ERROR.
- `hrdata` out DW: read data.
- `reg_req` out 1: register access request.
- `reg_we` out 1: 1 = write.
- `reg_addr` out AW: byte address, aligned to the transfer size.
- `reg_wdata` out DW: equals `hwdata` while `reg_req` is high.
- `reg_wstrb` out DW/8: byte enables.
- `reg_ack` in 1: access complete.
- `reg_err` in 1: access failed; sampled only when `reg_ack` is high.
- `reg_rdata` in DW: read data; sampled only when `reg_ack` is high.

## Operation
- **Address-phase accept:** `hsel & hready & ahb_xfer(htrans)`. On accept, register `haddr`, `hwrite`, `hsize`, and the error check.
- **Error check at accept.** Any of the following gives an error:
  - `hsize > log2(DW/8)`
  - `haddr` not aligned to `2**hsize`
  - `REQ_PRIV==1` and `hprot[1]==0`
- **IDLE transfers:** IDLE, BUSY, or `hsel==0` with `hready==1` get a zero-wait OKAY response and no register access.
- **States and outputs:**
  - IDLE: `hreadyout=1`, OKAY.
  - WAIT: `reg_req=1`, `hreadyout=0`.
  - RESP: `hreadyout=1`, OKAY, `hrdata` valid.
  - ERR1: `hreadyout=0`, ERROR.
  - ERR2: `hreadyout=1`, ERROR.
- **Transitions:**
  - From IDLE, RESP or ERR2 (the ready states), re-evaluate the accept condition every cycle. Accept with no error goes to WAIT; accept with error goes to ERR1; no accept goes to IDLE.
  - WAIT with `reg_ack & ~reg_err` goes to RESP and captures `reg_rdata` into `hrdata`.
  - WAIT with `reg_ack & reg_err` goes to ERR1.
  - WAIT with no `reg_ack` stays in WAIT, with `reg_req` held and all `reg_*` outputs stable.
  - ERR1 always goes to ERR2.
- **Back-to-back transfers:** an address phase accepted in RESP or ERR2 goes straight to WAIT or ERR1, with no idle cycle.
- **`reg_wstrb`:** `((1<<(1<<hsize))-1) << haddr[log2(DW/8)-1:0]`. For reads it is the same mask.
- **`hrdata`:** holds its last captured value outside RESP. Reads that error leave `hrdata` unchanged.
- **Reset:** synchronous. The state goes to IDLE on the next edge, from any state.
  - Reset values: `hreadyout=1`, `hresp=OKAY`, `hrdata=0`, `reg_req=0`, `reg_we=0`, `reg_addr=0`, `reg_wstrb=0`.
  - Reset during WAIT drops `reg_req` with no ack required. A late `reg_ack` after reset is ignored.

## Timing
- Address phase at cycle N. WAIT begins at N+1 with `reg_req` high.
- If `reg_ack` arrives at cycle N+1+k, RESP (or ERR1) is at N+2+k.
- Minimum latency is one wait state (k=0): `hreadyout` is low for exactly one cycle.
- Error response: two cycles, ERR1 then ERR2. `hresp=ERROR` in both; `hreadyout` is 0 then 1.
- All AHB and `reg_*` outputs are registered, except `reg_wdata`, which is driven combinationally from `hwdata`.
- `hwdata` must be stable throughout WAIT, as the AHB spec already requires.

## Test plan
- Write `haddr=0x10`, `hsize=2`, `hwdata=0xDEADBEEF`, with `reg_ack` on the first WAIT cycle:
  - one cycle of `reg_req` with `reg_we=1`, `reg_addr=0x10`, `reg_wstrb=0xF`, `reg_wdata=0xDEADBEEF`;
  - then `hreadyout=1` and OKAY.
- Read `0x24`, with `reg_ack` delayed 3 cycles and `reg_rdata=0x12345678`:
  - `hreadyout` low for 4 cycles;
  - in RESP, `hrdata=0x12345678` and OKAY.
- Misaligned word read at `0x02` (`hsize=2`):
  - no `reg_req`;
  - ERROR with `hreadyout` 0 then 1.
- Same error at `hsize=3` with DW=32.
- INCR4 byte writes at `0x40..0x43`, back-to-back:
  - four accesses with `reg_wstrb` = 0x1, 0x2, 0x4, 0x8;
  - no idle cycle between RESP and the next WAIT.
- Read with `reg_err=1` on ack: ERR1, ERR2, and `hrdata` unchanged.
- With `REQ_PRIV=1`: a user access (`hprot=0x1`) gets ERROR and no `reg_req`.
- `reset` asserted mid-WAIT:
  - next cycle `reg_req=0`, `hreadyout=1`, `hrdata=0`;
  - a subsequent `reg_ack` pulse causes no state change.
